// File: rtl/router_fsm.sv
// router_fsm: packet-level control FSM for the 1x3 router, driving register-stage strobes
module router_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);
  typedef enum logic [2:0] {
    DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_AFTER_FULL,
    FIFO_FULL_STATE, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY
  } state_t;
  state_t state, nxt;
  logic [1:0] addr_q, addr;
  logic [3:0] empty_v, soft_v;
  logic sel_empty, soft_hit;
  // address 3 maps to a constant-zero slot so it never looks empty or soft-reset
  assign empty_v   = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_v    = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  assign addr      = (state == DECODE_ADDRESS) ? data_in : addr_q;
  assign sel_empty = empty_v[addr];
  assign soft_hit  = soft_v[addr_q] && state != DECODE_ADDRESS;
  always_comb begin
    nxt = state;
    unique case (state)
      DECODE_ADDRESS:     nxt = (pkt_valid && addr != 2'd3) ? (sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY) : DECODE_ADDRESS;
      LOAD_FIRST_DATA:    nxt = LOAD_DATA;
      LOAD_DATA:          nxt = fifo_full ? FIFO_FULL_STATE : (!pkt_valid ? LOAD_PARITY : LOAD_DATA);
      FIFO_FULL_STATE:    nxt = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    nxt = parity_done ? DECODE_ADDRESS : (low_pkt_valid ? LOAD_PARITY : LOAD_DATA);
      LOAD_PARITY:        nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY:    nxt = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
    endcase
    if (soft_hit) nxt = DECODE_ADDRESS;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= DECODE_ADDRESS;
      addr_q <= 2'd0;
    end else begin
      state  <= nxt;
      addr_q <= (state == DECODE_ADDRESS && pkt_valid) ? data_in : addr_q;
    end
  end
  assign detect_add    = state == DECODE_ADDRESS;
  assign lfd_state     = state == LOAD_FIRST_DATA;
  assign ld_state      = state == LOAD_DATA;
  assign laf_state     = state == LOAD_AFTER_FULL;
  assign full_state    = state == FIFO_FULL_STATE;
  assign rst_int_reg   = state == CHECK_PARITY_ERROR;
  assign write_enb_reg = state == LOAD_DATA || state == LOAD_PARITY || state == LOAD_AFTER_FULL;
  assign busy          = !(state == DECODE_ADDRESS || state == LOAD_DATA);
endmodule

// File: doc/router_fsm.md
# router_fsm

Packet-level control state machine for the 1x3 router, sitting directly upstream of the router register stage. It watches the incoming byte stream (`pkt_valid`, header address bits), the status of the three output FIFOs and the register stage's parity flags, and produces the per-state strobes that tell the register stage when to latch the header, load payload, hold on FIFO-full and check parity. It also drives `busy` back to the source and `write_enb_reg` toward the FIFO write path.

## Interface
- No parameters; state encoding is internal, 8 states, 3-bit binary.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; forces state to DECODE_ADDRESS and clears the latched address.
- `pkt_valid` in 1: source byte valid; high through header and payload, low on the parity byte.
- `data_in` in 2: header address bits [1:0]; 0/1/2 select an output port, 3 is invalid.
- `fifo_full` in 1: full flag of the currently selected output FIFO.
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2` in 1 each: per-port FIFO empty flags.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` in 1 each: per-port read-timeout resets.
- `parity_done` in 1: register stage has captured the parity byte.
- `low_pkt_valid` in 1: register stage saw `pkt_valid` fall while data was pending.
- `detect_add` out 1: high in DECODE_ADDRESS.
- `lfd_state` out 1: high in LOAD_FIRST_DATA.
- `ld_state` out 1: high in LOAD_DATA.
- `laf_state` out 1: high in LOAD_AFTER_FULL.
- `full_state` out 1: high in FIFO_FULL_STATE.
- `rst_int_reg` out 1: high in CHECK_PARITY_ERROR.
- `write_enb_reg` out 1: high in LOAD_DATA, LOAD_PARITY or LOAD_AFTER_FULL.
- `busy` out 1: high in every state except DECODE_ADDRESS and LOAD_DATA.

## Operation
- The block is a Moore machine. All outputs decode combinationally from the state register and nothing else.
- Address latch `addr_q` (2 bits):
  - Loads `data_in` when the state is DECODE_ADDRESS and `pkt_valid` is high.
  - Holds its value otherwise.
  - Reset value is 0.
- In the transitions below, "addr" means `data_in` while in DECODE_ADDRESS, and `addr_q` in every other state.
- DECODE_ADDRESS:
  - `pkt_valid` high, addr k in {0,1,2}, `fifo_empty_k` high: go to LOAD_FIRST_DATA.
  - `pkt_valid` high, addr k in {0,1,2}, `fifo_empty_k` low: go to WAIT_TILL_EMPTY.
  - `pkt_valid` low, or addr == 3: stay. An invalid header is dropped.
- LOAD_FIRST_DATA: go to LOAD_DATA unconditionally.
- LOAD_DATA:
  - `fifo_full` high: go to FIFO_FULL_STATE.
  - Else `pkt_valid` low: go to LOAD_PARITY.
  - Else: stay.
- FIFO_FULL_STATE: `fifo_full` low goes to LOAD_AFTER_FULL; otherwise stay.
- LOAD_AFTER_FULL:
  - `parity_done` high: go to DECODE_ADDRESS.
  - Else `low_pkt_valid` high: go to LOAD_PARITY.
  - Else: go to LOAD_DATA.
- LOAD_PARITY: go to CHECK_PARITY_ERROR unconditionally.
- CHECK_PARITY_ERROR: `fifo_full` high goes to FIFO_FULL_STATE; otherwise go to DECODE_ADDRESS.
- WAIT_TILL_EMPTY: `fifo_empty` of `addr_q` high goes to LOAD_FIRST_DATA; otherwise stay.
- Soft reset:
  - `soft_reset_k` high while `addr_q` == k, in any state other than DECODE_ADDRESS, forces the next state to DECODE_ADDRESS.
  - It overrides every other transition.
  - Soft resets for non-selected ports are ignored.

## Timing
- The state register updates on `posedge clock`. Outputs change in the same cycle the state changes, with no extra pipeline stage.
- Reset values: state is DECODE_ADDRESS, so `detect_add`=1. All other outputs are 0, `busy`=0, `addr_q`=0.
- Reset asserted mid-packet returns the block to DECODE_ADDRESS immediately (asynchronous), regardless of clock.
- Minimum packet path with an empty FIFO and no full events:
  - 1 cycle each in DECODE_ADDRESS and LOAD_FIRST_DATA.
  - N cycles in LOAD_DATA for N payload bytes.
  - 1 cycle each in LOAD_PARITY and CHECK_PARITY_ERROR.
  - Total N+4 cycles from header to ready.
- `busy` rises in the cycle after the header is accepted and stays high through the LOAD_FIRST_DATA cycle, so the source holds its first payload byte for one cycle.
- Simultaneous `fifo_full` and `pkt_valid` falling in LOAD_DATA: `fifo_full` wins and the next state is FIFO_FULL_STATE.
- Simultaneous soft reset and `fifo_full`: soft reset wins.

## Test plan
- Reset then header 0x12 (addr 2, length 4) with `fifo_empty_2`=1, 4 payload bytes, parity → state sequence DA, LFD, LD×4, LP, CPE, DA. `write_enb_reg` is high for 5 cycles and `busy` is high in LFD, LP and CPE.
- Header addr 1 with `fifo_empty_1`=0 for 3 cycles, then 1 → WAIT_TILL_EMPTY for 3 cycles with `busy`=1, then LFD.
- `fifo_full`=1 during the 2nd LD cycle for 2 cycles → FFS×2 with `full_state`=1 and `write_enb_reg`=0. Then LAF, and with `parity_done`=0 and `low_pkt_valid`=0 the machine returns to LD.
- In LAF with `parity_done`=1 → next state DA. With `parity_done`=0 and `low_pkt_valid`=1 → next state LP.
- Header 0x03 (addr 3) with `pkt_valid`=1 → stays in DA with `detect_add`=1 and `busy`=0.
- In WAIT_TILL_EMPTY for addr 0, pulse `soft_reset_1` → no effect. Pulse `soft_reset_0` → DA the next cycle. Async `reset` pulse mid-LD → DA immediately with `ld_state`=0.
